// File: rtl/fp_add_pipe_if.sv
// Operand/result bundle for the pipelined FP add/sub core.
// The driver owns the operand side and out_ready; the core owns in_ready and the result side.
interface fp_add_pipe_if #(
    parameter int EW = 11,
    parameter int FW = 52
);
    logic          in_valid;
    logic          in_ready;
    logic [FW:0]   fa;
    logic [FW:0]   fb;
    logic [EW-1:0] ea;
    logic [EW-1:0] eb;
    logic          sa;
    logic          sb;
    logic          sub;
    logic [3:0]    fla;
    logic [3:0]    flb;
    logic [FW:0]   nan;
    logic [1:0]    rm;

    logic          out_valid;
    logic          out_ready;
    logic [EW-1:0] es;
    logic [FW+4:0] fs;
    logic          ss;
    logic [1:0]    fls;
    logic          nans;
    logic          inv;
    logic [1:0]    rm_o;

    modport master (
        output in_valid, fa, fb, ea, eb, sa, sb, sub, fla, flb, nan, rm, out_ready,
        input  in_ready, out_valid, es, fs, ss, fls, nans, inv, rm_o
    );

    modport slave (
        input  in_valid, fa, fb, ea, eb, sa, sb, sub, fla, flb, nan, rm, out_ready,
        output in_ready, out_valid, es, fs, ss, fls, nans, inv, rm_o
    );
endinterface

// File: rtl/fp_add_pipe.sv
// Three-stage elastic FP add/sub core: align -> significand add -> special-case select.
// Result is left unrounded ({carry, int, frac, G, R, S}) for a downstream normalise/round stage.
// Operand class flags are {NAN, INF, ZERO, DENORM}; DENORM needs no handling here.
module fp_add_pipe #(
    parameter int EW = 11,
    parameter int FW = 52
) (
    input logic          clk,
    input logic          rst_n,
    fp_add_pipe_if.slave bus
);

    // Aligned significand width: hidden bit + fraction + guard/round/sticky.
    localparam int XW = FW + 4;
    localparam int SW = $clog2(XW + 1);
    localparam logic [EW-1:0] SH_MAX = EW'(XW);
    localparam logic [SW-1:0] SH_SAT = SW'(XW);

    // ------------------------------------------------------------------
    // Handshake chain
    // ------------------------------------------------------------------
    logic v1_q, v2_q, v3_q;
    logic ld1, ld2, ld3;

    // A stage may load when it is empty or its contents move on this cycle.
    always_comb begin
        ld3 = !v3_q || bus.out_ready;
        ld2 = !v2_q || ld3;
        ld1 = !v1_q || ld2;
    end

    assign bus.in_ready  = ld1;
    assign bus.out_valid = v3_q;

    // Denormal operands arrive pre-unpacked with e=1, so the flag is not consumed.
    logic unused_denorm;
    assign unused_denorm = bus.fla[0] ^ bus.flb[0];

    // ------------------------------------------------------------------
    // Stage 1: swap so the larger exponent leads, then align the smaller
    // ------------------------------------------------------------------
    logic          sbe;
    logic          swap;
    logic [EW-1:0] e_big, e_sml, e_dif;
    logic [FW:0]   f_big, f_sml;
    logic          s_big, s_sml;
    logic [SW-1:0] sh;
    logic [XW-1:0] x_big, x_sml, x_shf, x_lost, x_aln;

    // Alignment shift saturates at the full width; everything pushed out folds into sticky.
    always_comb begin
        sbe    = bus.sb ^ bus.sub;
        swap   = bus.ea < bus.eb;
        e_big  = swap ? bus.eb : bus.ea;
        e_sml  = swap ? bus.ea : bus.eb;
        f_big  = swap ? bus.fb : bus.fa;
        f_sml  = swap ? bus.fa : bus.fb;
        s_big  = swap ? sbe : bus.sa;
        s_sml  = swap ? bus.sa : sbe;
        e_dif  = e_big - e_sml;
        sh     = (e_dif > SH_MAX) ? SH_SAT : e_dif[SW-1:0];
        x_big  = {f_big, 3'b000};
        x_sml  = {f_sml, 3'b000};
        x_shf  = x_sml >> sh;
        x_lost = x_sml << (SH_SAT - sh);
        x_aln  = x_shf | {{(XW-1){1'b0}}, |x_lost};
    end

    logic [XW-1:0] xb1_q, xs1_q;
    logic [EW-1:0] e1_q;
    logic          sx1_q, sy1_q, sa1_q, sbe1_q;
    logic [2:0]    fla1_q, flb1_q;
    logic [FW:0]   nan1_q;
    logic [1:0]    rm1_q;

    // Stage 1 register: aligned operands plus everything the later stages need.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            xb1_q  <= '0;
            xs1_q  <= '0;
            e1_q   <= '0;
            sx1_q  <= 1'b0;
            sy1_q  <= 1'b0;
            sa1_q  <= 1'b0;
            sbe1_q <= 1'b0;
            fla1_q <= '0;
            flb1_q <= '0;
            nan1_q <= '0;
            rm1_q  <= '0;
        end else begin
            if (ld1) v1_q <= bus.in_valid;
            if (ld1 && bus.in_valid) begin
                xb1_q  <= x_big;
                xs1_q  <= x_aln;
                e1_q   <= e_big;
                sx1_q  <= s_big;
                sy1_q  <= s_sml;
                sa1_q  <= bus.sa;
                sbe1_q <= sbe;
                fla1_q <= bus.fla[3:1];
                flb1_q <= bus.flb[3:1];
                nan1_q <= bus.nan;
                rm1_q  <= bus.rm;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: magnitude add/subtract
    // ------------------------------------------------------------------
    logic          eff_sub;
    logic [XW+1:0] sum_w, sum_neg;
    logic          neg;
    logic [XW:0]   mag_c;
    logic          ss_c;

    // Only an equal-exponent subtract can go negative; flip it back to a magnitude.
    always_comb begin
        eff_sub = sx1_q ^ sy1_q;
        sum_w   = eff_sub ? ({2'b00, xb1_q} - {2'b00, xs1_q})
                          : ({2'b00, xb1_q} + {2'b00, xs1_q});
        sum_neg = -sum_w;
        neg     = eff_sub & sum_w[XW+1];
        mag_c   = neg ? sum_neg[XW:0] : sum_w[XW:0];
        ss_c    = neg ? !sx1_q : sx1_q;
    end

    logic [XW:0]   mag2_q;
    logic          ss2_q, z2_q, sa2_q, sbe2_q;
    logic [EW-1:0] e2_q;
    logic [2:0]    fla2_q, flb2_q;
    logic [FW:0]   nan2_q;
    logic [1:0]    rm2_q;

    // Stage 2 register: raw sum and its sign, operand classes carried alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q   <= 1'b0;
            mag2_q <= '0;
            ss2_q  <= 1'b0;
            z2_q   <= 1'b0;
            sa2_q  <= 1'b0;
            sbe2_q <= 1'b0;
            e2_q   <= '0;
            fla2_q <= '0;
            flb2_q <= '0;
            nan2_q <= '0;
            rm2_q  <= '0;
        end else begin
            if (ld2) v2_q <= v1_q;
            if (ld2 && v1_q) begin
                mag2_q <= mag_c;
                ss2_q  <= ss_c;
                z2_q   <= (mag_c == '0);
                sa2_q  <= sa1_q;
                sbe2_q <= sbe1_q;
                e2_q   <= e1_q;
                fla2_q <= fla1_q;
                flb2_q <= flb1_q;
                nan2_q <= nan1_q;
                rm2_q  <= rm1_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: special-case select (NaN > INF > exact zero > normal)
    // ------------------------------------------------------------------
    logic          inf_inf;
    logic [EW-1:0] es_d;
    logic [XW:0]   fs_d;
    logic          ss_d, nans_d, inv_d;
    logic [1:0]    fls_d;

    // Class flags here are {NAN, INF, ZERO}; -0 only survives when both inputs are -0,
    // otherwise an exact zero takes its sign from the rounding direction.
    always_comb begin
        inf_inf = fla2_q[1] & flb2_q[1] & (sa2_q ^ sbe2_q);
        es_d    = e2_q;
        fs_d    = mag2_q;
        ss_d    = ss2_q;
        fls_d   = 2'b00;
        nans_d  = 1'b0;
        inv_d   = 1'b0;
        if (fla2_q[2] || flb2_q[2] || inf_inf) begin
            nans_d = 1'b1;
            inv_d  = inf_inf;
            es_d   = '1;
            fs_d   = {1'b0, nan2_q, 3'b000};
            ss_d   = 1'b0;
        end else if (fla2_q[1] || flb2_q[1]) begin
            fls_d = 2'b10;
            es_d  = '1;
            fs_d  = {2'b01, {(XW-1){1'b0}}};
            ss_d  = fla2_q[1] ? sa2_q : sbe2_q;
        end else if (z2_q) begin
            fls_d = 2'b01;
            es_d  = '0;
            fs_d  = '0;
            ss_d  = (fla2_q[0] && flb2_q[0] && (sa2_q == sbe2_q)) ? (sa2_q & sbe2_q)
                                                                 : (rm2_q == 2'b11);
        end
    end

    logic [EW-1:0] es_q;
    logic [XW:0]   fs_q;
    logic          ss_q, nans_q, inv_q;
    logic [1:0]    fls_q, rm3_q;

    // Output register: only loads while the consumer is not stalling it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q   <= 1'b0;
            es_q   <= '0;
            fs_q   <= '0;
            ss_q   <= 1'b0;
            fls_q  <= '0;
            nans_q <= 1'b0;
            inv_q  <= 1'b0;
            rm3_q  <= '0;
        end else begin
            if (ld3) v3_q <= v2_q;
            if (ld3 && v2_q) begin
                es_q   <= es_d;
                fs_q   <= fs_d;
                ss_q   <= ss_d;
                fls_q  <= fls_d;
                nans_q <= nans_d;
                inv_q  <= inv_d;
                rm3_q  <= rm2_q;
            end
        end
    end

    assign bus.es   = es_q;
    assign bus.fs   = fs_q;
    assign bus.ss   = ss_q;
    assign bus.fls  = fls_q;
    assign bus.nans = nans_q;
    assign bus.inv  = inv_q;
    assign bus.rm_o = rm3_q;

endmodule

// File: tb/tb_fp_add_pipe.sv
// Bench for fp_add_pipe: directed IEEE corner cases, backpressure, reset flush,
// then a random run scored against an arithmetic reference model.
module tb_fp_add_pipe;
    localparam int EW = 11;
    localparam int FW = 52;
    localparam logic [52:0] ONE  = 53'h10000000000000;
    localparam logic [52:0] ONE5 = 53'h18000000000000;
    localparam logic [52:0] QNAN = 53'h18000000000000;

    typedef struct packed {
        logic [52:0] fa;
        logic [52:0] fb;
        logic [52:0] nan;
        logic [10:0] ea;
        logic [10:0] eb;
        logic        sa;
        logic        sb;
        logic        sub;
        logic [3:0]  fla;
        logic [3:0]  flb;
        logic [1:0]  rm;
    } op_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    logic [74:0] exp_q[$];
    logic        hold_q = 1'b0;
    logic [74:0] held = '0;

    fp_add_pipe_if #(.EW(EW), .FW(FW)) bus ();
    fp_add_pipe #(.EW(EW), .FW(FW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [74:0] pk(input logic [10:0] es, input logic [56:0] fs, input logic ss,
                                       input logic [1:0] fls, input logic nans, input logic inv,
                                       input logic [1:0] rm);
        return {es, fs, ss, fls, nans, inv, rm};
    endfunction

    function automatic logic [74:0] snap();
        return {bus.es, bus.fs, bus.ss, bus.fls, bus.nans, bus.inv, bus.rm_o};
    endfunction

    // Reference: real signed arithmetic on the 3-bit-extended significands.
    function automatic logic [74:0] model(input op_t o);
        logic        sbe, nan_any, inf_inf, sx, sy;
        logic [10:0] ebig, esml;
        longint      bm, sm, al, r, mg;
        int          d;
        sbe     = o.sb ^ o.sub;
        nan_any = o.fla[3] | o.flb[3];
        inf_inf = o.fla[2] & o.flb[2] & (o.sa != sbe);
        if (nan_any || inf_inf)
            return pk(11'h7FF, {1'b0, o.nan, 3'b000}, 1'b0, 2'b00, 1'b1, inf_inf, o.rm);
        if (o.fla[2] || o.flb[2])
            return pk(11'h7FF, {2'b01, 55'h0}, o.fla[2] ? o.sa : sbe, 2'b10, 1'b0, 1'b0, o.rm);
        bm = 0;
        sm = 0;
        if (o.ea < o.eb) begin
            ebig = o.eb; esml = o.ea; bm[55:0] = {o.fb, 3'b000}; sm[55:0] = {o.fa, 3'b000};
            sx = sbe; sy = o.sa;
        end else begin
            ebig = o.ea; esml = o.eb; bm[55:0] = {o.fa, 3'b000}; sm[55:0] = {o.fb, 3'b000};
            sx = o.sa; sy = sbe;
        end
        d = int'(ebig) - int'(esml);
        if (d >= 56) al = (sm != 0) ? 64'sd1 : 64'sd0;
        else         al = (sm >> d) | (((sm & ((64'sd1 <<< d) - 1)) != 0) ? 64'sd1 : 64'sd0);
        r  = (sx ? -bm : bm) + (sy ? -al : al);
        mg = (r < 0) ? -r : r;
        if (mg == 0)
            return pk(11'h0, 57'h0,
                      (o.fla[1] && o.flb[1] && (o.sa == sbe)) ? o.sa : (o.rm == 2'b11),
                      2'b01, 1'b0, 1'b0, o.rm);
        return pk(ebig, mg[56:0], r < 0, 2'b00, 1'b0, 1'b0, o.rm);
    endfunction

    function automatic op_t mk(input logic [52:0] fa, input logic [52:0] fb, input logic [10:0] ea,
                               input logic [10:0] eb, input logic sa, input logic sb, input logic sub,
                               input logic [3:0] fla, input logic [3:0] flb, input logic [1:0] rm);
        op_t o;
        o = '0;
        o.fa = fa; o.fb = fb; o.ea = ea; o.eb = eb; o.sa = sa; o.sb = sb; o.sub = sub;
        o.fla = fla; o.flb = flb; o.rm = rm; o.nan = QNAN;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t         o;
        logic [63:0] r64;
        int          k;
        o = '0;
        r64 = {$urandom(), $urandom()};
        o.fa = {1'b1, r64[51:0]};
        r64 = {$urandom(), $urandom()};
        o.fb = {1'b1, r64[51:0]};
        o.nan = {2'b11, r64[50:0]};
        o.ea = 11'(900 + $urandom_range(0, 150));
        k = $urandom_range(0, 15);
        o.eb = (k < 5) ? o.ea : 11'(900 + $urandom_range(0, 150));
        if (k < 2) o.fb = o.fa;
        o.sa = 1'($urandom_range(0, 1));
        o.sb = 1'($urandom_range(0, 1));
        o.sub = 1'($urandom_range(0, 1));
        o.rm = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 31))
            0: o.fla = 4'b1000;
            1: o.flb = 4'b1000;
            2: begin o.fla = 4'b0100; o.ea = 11'h7FF; o.fa = '0; end
            3: begin o.flb = 4'b0100; o.eb = 11'h7FF; o.fb = '0; end
            4: begin o.fla = 4'b0100; o.flb = 4'b0100; o.ea = 11'h7FF; o.eb = 11'h7FF; end
            5: begin o.fla = 4'b0010; o.ea = '0; o.fa = '0; end
            6: begin o.fla = 4'b0010; o.flb = 4'b0010; o.ea = '0; o.eb = '0; o.fa = '0; o.fb = '0; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic chk(input string tag, input logic [74:0] obs, input logic [74:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic observe();
        logic [74:0] cur;
        cur = snap();
        if (hold_q) begin
            chk("hold_valid", 75'(bus.out_valid), 75'(1));
            chk("frozen", cur, held);
        end
        if (bus.out_valid && bus.out_ready) begin
            chk("result_expected", 75'(exp_q.size() != 0), 75'(1));
            if (exp_q.size() != 0) chk("result", cur, exp_q.pop_front());
        end
        hold_q = bus.out_valid && !bus.out_ready;
        held   = cur;
    endtask

    task automatic run_cycle(input logic iv, input op_t o, input logic ordy, output logic acc);
        @(negedge clk);
        bus.in_valid = iv;
        bus.fa = o.fa; bus.fb = o.fb; bus.ea = o.ea; bus.eb = o.eb;
        bus.sa = o.sa; bus.sb = o.sb; bus.sub = o.sub;
        bus.fla = o.fla; bus.flb = o.flb; bus.nan = o.nan; bus.rm = o.rm;
        bus.out_ready = ordy;
        #2;
        observe();
        acc = iv && bus.in_ready && rst_n;
        if (acc) exp_q.push_back(model(o));
    endtask

    task automatic send_op(input op_t o, input logic ordy);
        logic acc;
        int   t;
        acc = 1'b0;
        t = 0;
        while (!acc && t < 40) begin
            run_cycle(1'b1, o, ordy, acc);
            t++;
        end
        chk("accept", 75'(acc), 75'(1));
    endtask

    task automatic idle(input int n, input logic ordy);
        logic acc;
        for (int i = 0; i < n; i++) run_cycle(1'b0, '0, ordy, acc);
    endtask

    // Sends one op into an empty pipe and checks the first result against a constant.
    task automatic dir_check(input string tag, input op_t o, input logic [74:0] expv, output int lat);
        logic acc, found;
        send_op(o, 1'b1);
        lat = 0;
        found = 1'b0;
        while (!found && lat < 10) begin
            run_cycle(1'b0, '0, 1'b1, acc);
            lat++;
            if (bus.out_valid) begin
                found = 1'b1;
                chk(tag, snap(), expv);
            end
        end
        chk({tag, "_seen"}, 75'(found), 75'(1));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && t < 60) begin
            idle(1, 1'b1);
            t++;
        end
        chk("drain_empty", 75'(exp_q.size()), 75'(0));
    endtask

    initial begin
        op_t  ops[5];
        op_t  cur;
        logic acc;
        int   lat, k;

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.fa = '0; bus.fb = '0; bus.ea = '0; bus.eb = '0; bus.sa = 1'b0; bus.sb = 1'b0;
        bus.sub = 1'b0; bus.fla = '0; bus.flb = '0; bus.nan = '0; bus.rm = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 75'(bus.out_valid), 75'(0));
        chk("reset_in_ready", 75'(bus.in_ready), 75'(1));
        chk("reset_outputs", snap(), 75'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic and special cases
        dir_check("one_plus_one", mk(ONE, ONE, 11'd1023, 11'd1023, 0, 0, 0, 4'b0, 4'b0, 2'b00),
                  pk(11'd1023, {1'b1, 56'h0}, 0, 2'b00, 0, 0, 2'b00), lat);
        chk("latency", 75'(lat), 75'(3));
        dir_check("one_minus_one_rne", mk(ONE, ONE, 11'd1023, 11'd1023, 0, 0, 1, 4'b0, 4'b0, 2'b00),
                  pk(11'd0, 57'h0, 0, 2'b01, 0, 0, 2'b00), lat);
        dir_check("one_minus_one_rd", mk(ONE, ONE, 11'd1023, 11'd1023, 0, 0, 1, 4'b0, 4'b0, 2'b11),
                  pk(11'd0, 57'h0, 1, 2'b01, 0, 0, 2'b11), lat);
        dir_check("negzero_plus_negzero", mk('0, '0, 11'd0, 11'd0, 1, 1, 0, 4'b0010, 4'b0010, 2'b00),
                  pk(11'd0, 57'h0, 1, 2'b01, 0, 0, 2'b00), lat);
        dir_check("inf_minus_inf", mk('0, '0, 11'h7FF, 11'h7FF, 0, 1, 0, 4'b0100, 4'b0100, 2'b00),
                  pk(11'h7FF, {1'b0, QNAN, 3'b000}, 0, 2'b00, 1, 1, 2'b00), lat);
        dir_check("inf_plus_one", mk('0, ONE, 11'h7FF, 11'd1023, 0, 0, 0, 4'b0100, 4'b0000, 2'b00),
                  pk(11'h7FF, {2'b01, 55'h0}, 0, 2'b10, 0, 0, 2'b00), lat);
        dir_check("nan_input", mk(ONE, ONE, 11'd1023, 11'd1023, 0, 0, 0, 4'b1000, 4'b0000, 2'b10),
                  pk(11'h7FF, {1'b0, QNAN, 3'b000}, 0, 2'b00, 1, 0, 2'b10), lat);
        dir_check("sticky_saturate", mk(ONE, ONE, 11'd1023, 11'd963, 0, 0, 0, 4'b0, 4'b0, 2'b00),
                  pk(11'd1023, {1'b0, ONE, 3'b001}, 0, 2'b00, 0, 0, 2'b00), lat);
        dir_check("negative_difference", mk(ONE, ONE5, 11'd1023, 11'd1023, 0, 0, 1, 4'b0, 4'b0, 2'b01),
                  pk(11'd1023, {3'b001, 54'h0}, 1, 2'b00, 0, 0, 2'b01), lat);
        dir_check("swap_add", mk(ONE, ONE, 11'd1022, 11'd1023, 0, 0, 0, 4'b0, 4'b0, 2'b00),
                  pk(11'd1023, {3'b011, 54'h0}, 0, 2'b00, 0, 0, 2'b00), lat);

        // Backpressure: consumer stalled while five ops are offered
        for (int i = 0; i < 5; i++) ops[i] = rand_op();
        k = 0;
        for (int c = 0; c < 6; c++) begin
            run_cycle(k < 5, ops[k < 5 ? k : 4], 1'b0, acc);
            if (acc) k++;
        end
        chk("bp_accepted", 75'(k), 75'(3));
        chk("bp_in_ready", 75'(bus.in_ready), 75'(0));
        for (int c = 0; c < 5; c++) begin
            run_cycle(k < 5, ops[k < 5 ? k : 4], 1'b1, acc);
            if (acc) k++;
            chk("bp_drain_rate", 75'(bus.out_valid), 75'(1));
        end
        chk("bp_all_accepted", 75'(k), 75'(5));
        drain();

        // Reset with ops in flight
        for (int i = 0; i < 3; i++) send_op(rand_op(), 1'b0);
        idle(1, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 75'(bus.out_valid), 75'(0));
        chk("midrst_in_ready", 75'(bus.in_ready), 75'(1));
        exp_q.delete();
        hold_q = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dir_check("after_reset", mk(ONE, ONE, 11'd1023, 11'd963, 0, 0, 0, 4'b0, 4'b0, 2'b00),
                  pk(11'd1023, {1'b0, ONE, 3'b001}, 0, 2'b00, 0, 0, 2'b00), lat);
        drain();

        // Random traffic with random consumer stalls
        cur = rand_op();
        for (int i = 0; i < 400; i++) begin
            run_cycle($urandom_range(0, 3) != 0, cur, $urandom_range(0, 9) < 7, acc);
            if (acc) cur = rand_op();
        end
        idle(1, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
